// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C command sequencer.
// The command entry is packed as {rd, addr[6:0], data[7:0]}.
package i2c_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } seq_state_e;

    localparam int CMD_W               = 16;
    localparam int TIMEOUT_CYC_DEFAULT = 65535;

    typedef struct packed {
        logic       rd;
        logic [6:0] addr;
        logic [7:0] data;
    } cmd_t;

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Circular command FIFO with one extra pointer bit to tell full from empty.
// Push is dropped when full, pop is dropped when empty; both may happen on one edge.
module i2c_cmd_fifo
    import i2c_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = CMD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i & ~empty_o;
    assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];

    // Advance the read and write pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    // Store pushed entries; storage is cleared so rdata is defined after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Upstream feeder for the I2C master: queues host commands, issues them one at a
// time, and returns one response per command. At most one command is outstanding.
// Optional transaction timeout is enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_data,
    input  logic       cmd_rd,
    output logic       m_start,
    output logic [6:0] m_address,
    output logic [7:0] m_data_in,
    input  logic       m_done,
    input  logic [7:0] m_data_out,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       busy
);

    seq_state_e state_q;
    seq_state_e state_d;

    cmd_t       fifo_wdata_s;
    cmd_t       fifo_rdata_s;
    logic       fifo_full_s;
    logic       fifo_empty_s;
    logic       push_s;
    logic       pop_s;
    logic       done_s;
    logic       timeout_s;

    logic [6:0] m_address_q;
    logic [7:0] m_data_in_q;
    logic       rd_q;
    logic       rsp_valid_q;
    logic [7:0] rsp_data_q;
    logic       rsp_err_q;

    assign cmd_ready    = ~fifo_full_s;
    assign push_s       = cmd_valid & ~fifo_full_s;
    assign fifo_wdata_s = '{rd: cmd_rd, addr: cmd_addr, data: cmd_data};
    assign done_s       = (state_q == ST_WAIT) & m_done;

    i2c_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_s),
        .wdata_i (fifo_wdata_s),
        .pop_i   (pop_s),
        .rdata_o (fifo_rdata_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    logic [15:0] to_cnt_q;

    // Count WAIT cycles; restart from zero while the start pulse is out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q <= 16'd0;
        end else if (state_q == ST_ISSUE) begin
            to_cnt_q <= 16'd0;
        end else if (state_q == ST_WAIT) begin
            to_cnt_q <= to_cnt_q + 16'd1;
        end
    end

    // m_done in the expiry cycle counts as a normal completion.
    assign timeout_s = (state_q == ST_WAIT) & ~m_done & (to_cnt_q == TO_LAST);
`else
    logic unused_timeout_cfg_s;

    assign unused_timeout_cfg_s = (TIMEOUT_CYC != 0);
    assign timeout_s            = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a new command is only taken once the previous response is gone.
    always_comb begin
        state_d = state_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s && !rsp_valid_q) begin
                    state_d = ST_ISSUE;
                    pop_s   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_s || timeout_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the state register and held datapath registers.
    always_comb begin
        m_start   = (state_q == ST_ISSUE);
        busy      = (state_q != ST_IDLE) | ~fifo_empty_s;
        m_address = m_address_q;
        m_data_in = m_data_in_q;
        rsp_valid = rsp_valid_q;
        rsp_data  = rsp_data_q;
        rsp_err   = rsp_err_q;
    end

    // Capture the popped entry; held stable until the next command is popped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_address_q <= 7'd0;
            m_data_in_q <= 8'd0;
            rd_q        <= 1'b0;
        end else if (pop_s) begin
            m_address_q <= fifo_rdata_s.addr;
            m_data_in_q <= fifo_rdata_s.data;
            rd_q        <= fifo_rdata_s.rd;
        end
    end

    // Response register: set on completion or timeout, cleared on host handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'd0;
            rsp_err_q   <= 1'b0;
        end else if (done_s) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= rd_q ? m_data_out : 8'h00;
            rsp_err_q   <= 1'b0;
        end else if (timeout_s) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= 8'h00;
            rsp_err_q   <= 1'b1;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Self-checking bench for i2c_cmd_sequencer. The reference model is a queue of
// accepted commands: each start must present the next queued command, and each
// response is rd ? master data : 0 (or an error response on timeout).
// Timeout scenarios are built when I2C_SEQ_TIMEOUT_EN is defined.
module tb_i2c_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int TO    = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       cmd_rd;
    logic       m_start;
    logic [6:0] m_address;
    logic [7:0] m_data_in;
    logic       m_done;
    logic [7:0] m_data_out;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       busy;

    int errors = 0;
    int checks = 0;

    int          cyc = 0;
    logic [14:0] start_log [$];
    int          start_cyc [$];
    logic [15:0] cmd_model [$];
    int          issued     = 0;
    int          start_base = 0;

    i2c_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_rd(cmd_rd),
        .m_start(m_start), .m_address(m_address), .m_data_in(m_data_in),
        .m_done(m_done), .m_data_out(m_data_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Log every start pulse with the command it carries and the edge count.
    always @(posedge clk) begin
        if (m_start === 1'b1) begin
            start_log.push_back({m_address, m_data_in});
            start_cyc.push_back(cyc);
        end
        cyc <= cyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic rd, input logic [6:0] a, input logic [7:0] d, output bit ok);
        ok        = 1'b0;
        cmd_valid = 1'b1;
        cmd_rd    = rd;
        cmd_addr  = a;
        cmd_data  = d;
        for (int i = 0; i < 64 && !ok; i++) begin
            ok = (cmd_ready === 1'b1);
            tick();
        end
        cmd_valid = 1'b0;
        if (ok) cmd_model.push_back({rd, a, d});
    endtask

    task automatic wait_start(input int n, output bit ok);
        for (int i = 0; i < 200 && start_log.size() < n; i++) tick();
        ok = (start_log.size() >= n);
    endtask

    task automatic finish_cmd(input int delay, input logic [7:0] d);
        repeat (delay) tick();
        m_done     = 1'b1;
        m_data_out = d;
        tick();
        m_done     = 1'b0;
        m_data_out = 8'($urandom);
    endtask

    task automatic take_rsp(input int lag, output bit got, output logic [8:0] v);
        got = 1'b0;
        v   = 9'h1FF;
        for (int i = 0; i < 200 && !got; i++) begin
            if (rsp_valid === 1'b1) got = 1'b1;
            else tick();
        end
        if (got) begin
            repeat (lag) tick();
            v         = {rsp_err, rsp_data};
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
    endtask

    // Serve the next queued command: wait for its start, complete it, collect the response.
    task automatic serve_next(input int delay, input logic [7:0] d, input int lag,
                              output logic [14:0] got_st, output logic [14:0] exp_st,
                              output logic [8:0] got_r, output logic [8:0] exp_r);
        bit ok_s;
        bit ok_r;
        exp_st = cmd_model[issued][14:0];
        exp_r  = cmd_model[issued][15] ? {1'b0, d} : 9'h000;
        wait_start(start_base + issued + 1, ok_s);
        got_st = ok_s ? start_log[start_base + issued] : 15'h7FFF;
        if (ok_s) finish_cmd(delay, d);
        take_rsp(lag, ok_r, got_r);
        issued++;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_addr = 7'd0; cmd_data = 8'd0; cmd_rd = 1'b0;
        m_done = 1'b0; m_data_out = 8'h5A; rsp_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if ({m_start, m_address, m_data_in, rsp_valid, rsp_data, rsp_err, busy, cmd_ready} !==
            {1'b0, 7'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_values: got start=%b addr=%h din=%h rv=%b rd=%h re=%b busy=%b rdy=%b",
                     m_start, m_address, m_data_in, rsp_valid, rsp_data, rsp_err, busy, cmd_ready);
        end
        reset = 1'b0;
        repeat (2) tick();
        checks++;
        if ({m_start, rsp_valid, busy, cmd_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL post_reset_idle: got %b want 0001", {m_start, rsp_valid, busy, cmd_ready});
        end
    endtask

    task automatic test_write();
        bit ok;
        bit got;
        logic [8:0] rv;
        int n0;
        push_cmd(1'b0, 7'h50, 8'hA5, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL write_push: got not_accepted want accepted"); end
        checks++;
        if ({m_start, busy} !== 2'b01) begin
            errors++; $display("FAIL write_no_bypass: got start,busy=%b want 01", {m_start, busy});
        end
        tick();
        checks++;
        if ({m_start, m_address, m_data_in} !== {1'b1, 7'h50, 8'hA5}) begin
            errors++; $display("FAIL write_issue: got start=%b addr=%h din=%h want 1 50 a5",
                               m_start, m_address, m_data_in);
        end
        tick();
        checks++;
        if ({m_start, m_address, m_data_in} !== {1'b0, 7'h50, 8'hA5}) begin
            errors++; $display("FAIL write_start_width: got start=%b addr=%h din=%h want 0 50 a5",
                               m_start, m_address, m_data_in);
        end
        repeat (8) tick();
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL write_early_rsp: got %b want 0", rsp_valid); end
        finish_cmd(0, 8'hC3);
        checks++;
        if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 8'h00}) begin
            errors++; $display("FAIL write_rsp: got v=%b e=%b d=%h want 1 0 00", rsp_valid, rsp_err, rsp_data);
        end
        n0 = start_log.size();
        m_done = 1'b1; m_data_out = 8'hEE;
        tick();
        m_done = 1'b0;
        tick();
        checks++;
        if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 8'h00} || start_log.size() != n0) begin
            errors++; $display("FAIL idle_done_ignored: got v=%b d=%h starts=%0d want 1 00 %0d",
                               rsp_valid, rsp_data, start_log.size(), n0);
        end
        take_rsp(0, got, rv);
        checks++;
        if (!got || {rsp_valid, busy} !== 2'b00) begin
            errors++; $display("FAIL write_rsp_clear: got v=%b busy=%b want 0 0", rsp_valid, busy);
        end
        issued++;
    endtask

    task automatic test_read();
        bit ok;
        logic [14:0] gs, es;
        logic [8:0]  gr, er;
        push_cmd(1'b1, 7'h68, 8'($urandom), ok);
        serve_next($urandom_range(0, 5), 8'h3C, 0, gs, es, gr, er);
        checks++;
        if (gs !== es) begin errors++; $display("FAIL read_issue: got %h want %h", gs, es); end
        checks++;
        if (gr !== 9'h03C) begin errors++; $display("FAIL read_rsp: got %h want 03c", gr); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit all_ok = 1'b1;
        bit stuck  = 1'b0;
        logic [14:0] gs, es;
        logic [8:0]  gr, er;
        for (int i = 0; i < 5; i++) begin
            push_cmd(1'($urandom), 7'($urandom), 8'($urandom), ok);
            all_ok &= ok;
        end
        checks++;
        if (!all_ok) begin errors++; $display("FAIL b2b_push5: got a refused push want all accepted"); end
        checks++;
        if ({cmd_ready, busy} !== 2'b01 || start_log.size() != start_base + issued + 1) begin
            errors++; $display("FAIL b2b_full: got rdy=%b busy=%b starts=%0d want 0 1 %0d",
                               cmd_ready, busy, start_log.size(), start_base + issued + 1);
        end
        cmd_valid = 1'b1; cmd_addr = 7'h7F; cmd_data = 8'hFF; cmd_rd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (cmd_ready !== 1'b0) stuck = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        checks++;
        if (stuck) begin errors++; $display("FAIL b2b_sixth: got cmd_ready=1 want 0 while full"); end
        for (int i = 0; i < 5; i++) begin
            serve_next($urandom_range(0, 4), 8'($urandom), $urandom_range(0, 2), gs, es, gr, er);
            checks++;
            if (gs !== es || gr !== er) begin
                errors++; $display("FAIL b2b_order%0d: got st=%h rsp=%h want st=%h rsp=%h", i, gs, gr, es, er);
            end
        end
    endtask

    task automatic test_rsp_backpressure();
        bit ok;
        bit bad = 1'b0;
        int n0;
        logic [14:0] gs, es;
        logic [8:0]  gr, er;
        push_cmd(1'b1, 7'h11, 8'h22, ok);
        push_cmd(1'b0, 7'h33, 8'h44, ok);
        wait_start(start_base + issued + 1, ok);
        finish_cmd(2, 8'h99);
        n0 = start_log.size();
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid !== 1'b1 || m_start !== 1'b0) bad = 1'b1;
            tick();
        end
        checks++;
        if (bad || start_log.size() != n0) begin
            errors++; $display("FAIL bp_hold: got starts=%0d bad=%b want %0d 0", start_log.size(), bad, n0);
        end
        take_rsp(0, ok, gr);
        checks++;
        if (gr !== 9'h099) begin errors++; $display("FAIL bp_rsp1: got %h want 099", gr); end
        issued++;
        serve_next(3, 8'h77, 1, gs, es, gr, er);
        checks++;
        if (gs !== es || gr !== er) begin
            errors++; $display("FAIL bp_second: got st=%h rsp=%h want st=%h rsp=%h", gs, gr, es, er);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        logic [14:0] gs, es;
        logic [8:0]  gr, er;
`ifdef I2C_SEQ_TIMEOUT_EN
        int l;
        int seen = -1;
        push_cmd(1'b1, 7'h2A, 8'h00, ok);
        wait_start(start_base + issued + 1, ok);
        l = start_cyc[start_base + issued];
        for (int i = 0; i < 100 && seen < 0; i++) begin
            if (rsp_valid === 1'b1) seen = cyc;
            else tick();
        end
        checks++;
        if (seen != l + TO + 1) begin
            errors++; $display("FAIL to_latency: got edge %0d want %0d", seen, l + TO + 1);
        end
        take_rsp(0, ok, gr);
        checks++;
        if (gr !== 9'h100) begin errors++; $display("FAIL to_rsp: got %h want 100", gr); end
        issued++;
        push_cmd(1'b1, 7'h2B, 8'h00, ok);
        wait_start(start_base + issued + 1, ok);
        l = start_cyc[start_base + issued];
        finish_cmd(l + TO - cyc, 8'h6D);
        take_rsp(0, ok, gr);
        checks++;
        if (gr !== 9'h06D) begin errors++; $display("FAIL to_done_wins: got %h want 06d", gr); end
        issued++;
`else
        bit bad = 1'b0;
        push_cmd(1'b1, 7'h2A, 8'h00, ok);
        wait_start(start_base + issued + 1, ok);
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) bad = 1'b1;
            tick();
        end
        checks++;
        if (bad) begin errors++; $display("FAIL no_timeout: got early response want none"); end
        finish_cmd(0, 8'h4E);
        take_rsp(0, ok, gr);
        checks++;
        if (gr !== 9'h04E) begin errors++; $display("FAIL no_timeout_rsp: got %h want 04e", gr); end
        issued++;
`endif
        push_cmd(1'b0, 7'h05, 8'h06, ok);
        serve_next(2, 8'h81, 0, gs, es, gr, er);
        checks++;
        if (gs !== es || gr !== er) begin
            errors++; $display("FAIL after_to_cmd: got st=%h rsp=%h want st=%h rsp=%h", gs, gr, es, er);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit bad = 1'b0;
        for (int i = 0; i < 3; i++) push_cmd(1'b1, 7'(i + 1), 8'(i), ok);
        wait_start(start_base + issued + 1, ok);
        repeat (3) tick();
        reset = 1'b1;
        #1;
        checks++;
        if ({m_start, m_address, m_data_in, rsp_valid, rsp_data, rsp_err, busy, cmd_ready} !==
            {1'b0, 7'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL mid_reset_values: got addr=%h rv=%b busy=%b rdy=%b",
                               m_address, rsp_valid, busy, cmd_ready);
        end
        repeat (2) tick();
        reset = 1'b0;
        cmd_model.delete();
        issued     = 0;
        start_base = start_log.size();
        m_done = 1'b1; m_data_out = 8'hAB;
        tick();
        m_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid !== 1'b0 || m_start !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) bad = 1'b1;
            tick();
        end
        checks++;
        if (bad || start_log.size() != start_base) begin
            errors++; $display("FAIL mid_reset_abandon: got activity=%b starts=%0d want 0 %0d",
                               bad, start_log.size(), start_base);
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [14:0] gs, es;
        logic [8:0]  gr, er;
        for (int i = 0; i < 8; i++) begin
            push_cmd(1'($urandom), 7'($urandom), 8'($urandom), ok);
            if ($urandom_range(0, 1) == 1) push_cmd(1'($urandom), 7'($urandom), 8'($urandom), ok);
            while (issued < cmd_model.size()) begin
                serve_next($urandom_range(0, 6), 8'($urandom_range(1, 255)), $urandom_range(0, 3),
                           gs, es, gr, er);
                checks++;
                if (gs !== es || gr !== er) begin
                    errors++; $display("FAIL random_cmd%0d: got st=%h rsp=%h want st=%h rsp=%h",
                                       issued - 1, gs, gr, es, er);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_rsp_backpressure();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
